// File: rtl/bg_output_xbar.sv
// Bank-group output selector: routes NUM_IN bank words to NUM_OUT lanes using a
// per-burst group select, then buffers the routed beats in a 2-entry FIFO.
module bg_output_xbar #(
  parameter int unsigned DW        = 256,
  parameter int unsigned NUM_IN    = 8,
  parameter int unsigned NUM_OUT   = 4,
  parameter int unsigned BURST_LEN = 4,
  localparam int unsigned G        = NUM_IN / NUM_OUT,
  localparam int unsigned SEL_W    = (G > 1) ? $clog2(G) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_IN*DW-1:0]   in_data,
  input  logic [SEL_W-1:0]       bg_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_OUT*DW-1:0]  out_data,
  output logic                   out_last,
  output logic                   sel_err
);

  localparam int unsigned BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned OUT_W  = NUM_OUT * DW;
  localparam logic [SEL_W:0]      G_L      = (SEL_W+1)'(G);
  localparam logic [BCNT_W-1:0]   BCNT_MAX = BCNT_W'(BURST_LEN - 1);

  logic [BCNT_W-1:0] bcnt_q;
  logic [SEL_W-1:0]  sel_q;
  logic              bad_q;
  logic              sel_err_q;
  logic [1:0]        count_q;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [OUT_W-1:0]  data_mem_q [2];
  logic [1:0]        last_mem_q;

  logic              accept;
  logic              xfer;
  logic              first;
  logic              beat_last;
  logic              sel_bad;
  logic [SEL_W-1:0]  sel_eff;
  logic [OUT_W-1:0]  lanes;

  // Ready depends only on buffer occupancy (and reset), never on out_ready.
  assign in_ready  = ~rst & (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = data_mem_q[rd_ptr_q];
  assign out_last  = last_mem_q[rd_ptr_q];
  assign sel_err   = sel_err_q;

  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign first     = (bcnt_q == '0);
  assign beat_last = (bcnt_q == BCNT_MAX);
  assign sel_eff   = first ? bg_sel : sel_q;
  assign sel_bad   = first ? ({1'b0, bg_sel} >= G_L) : bad_q;

  // Lane k takes word k*G+s; an out-of-range select leaves every lane zero.
  always_comb begin
    lanes = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      for (int g = 0; g < G; g++) begin
        if (!sel_bad && (sel_eff == SEL_W'(g))) begin
          lanes[k*DW +: DW] = in_data[(k*G + g)*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q        <= '0;
      sel_q         <= '0;
      bad_q         <= 1'b0;
      sel_err_q     <= 1'b0;
      count_q       <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      data_mem_q[0] <= '0;
      data_mem_q[1] <= '0;
      last_mem_q    <= 2'b00;
    end else begin
      if (accept) begin
        bcnt_q                 <= beat_last ? '0 : bcnt_q + BCNT_W'(1);
        data_mem_q[wr_ptr_q]   <= lanes;
        last_mem_q[wr_ptr_q]   <= beat_last;
        wr_ptr_q               <= ~wr_ptr_q;
        if (first) begin
          sel_q <= bg_sel;
          bad_q <= sel_bad;
        end
        if (sel_bad) begin
          sel_err_q <= 1'b1;
        end
      end
      if (xfer) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, accept} - {1'b0, xfer};
    end
  end

endmodule
